addr_gen_2d: RTL and testbench
==============================

Name: addr_gen_2d

Overview:
- Parametrised successor to the single-mode address calculator used by the image pipeline.
- Generates one pixel address per accepted handshake over a programmable width x height window with a programmable line stride.
- Supports independent row and column traversal direction (forward/reverse), so it covers raster, horizontally mirrored, vertically flipped and rotated-180 reads and writes.
- Sits between the controller FSM and the memory master; the master consumes addresses with a valid/ready handshake.

Parameters:
- ADDR_W, 32: address width in bits.
- DIM_W, 10: width of the width, height, row-count and column-count fields.
- PIX_BYTES, 4: byte increment between horizontally adjacent pixels.

Ports:
- clk  in  1  clock
- n_rst  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse; latches configuration, begins a frame
- abort  in  1  stop the current frame immediately
- start_addr  in  ADDR_W  address of the first pixel emitted
- img_width  in  DIM_W  pixels per row
- img_height  in  DIM_W  rows per frame
- line_stride  in  ADDR_W  byte distance between rows, unsigned
- col_dir  in  1  0: column step +PIX_BYTES, 1: column step -PIX_BYTES
- row_dir  in  1  0: row step +line_stride, 1: row step -line_stride
- addr_ready  in  1  consumer accepts addr this cycle
- addr  out  ADDR_W  current address
- addr_valid  out  1  addr is meaningful
- row_cnt  out  DIM_W  rows completed in the current frame, counts from 0
- col_cnt  out  DIM_W  column index within the current row, counts from 0
- new_row  out  1  high while addr is the first pixel of a row
- last  out  1  high while addr is the final pixel of the frame
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse at frame completion

Behaviour:
- Reset (n_rst low at a clk edge): all outputs 0; FSM goes to IDLE; latched configuration cleared. Reset mid-frame discards the frame with no done pulse.
- FSM states: IDLE, RUN, FIN.
  - IDLE, start=1, width and height both nonzero: latch the configuration; addr <= start_addr; row_base <= start_addr; counters <= 0; go to RUN. addr_valid, busy and new_row go high in the next cycle (one-cycle latency).
  - IDLE, start=1, width=0 or height=0: go to FIN; no address is emitted.
  - RUN: a transfer occurs when addr_valid and addr_ready are both 1.
    - Transfer, col_cnt < width-1: col_cnt++; addr += col_step.
    - Transfer, col_cnt = width-1, not last: col_cnt <= 0; row_cnt++; row_base += row_step; addr <= row_base + row_step.
    - Transfer on last: go to FIN; addr_valid drops in the next cycle.
    - No transfer: addr and all counters hold. addr_valid stays high; it is never withdrawn without a transfer except by abort or reset.
  - FIN: done=1 for exactly one cycle; busy=0; return to IDLE.
- new_row = RUN and col_cnt=0.
- last = RUN and col_cnt=width-1 and row_cnt=height-1.
- Width 1: every pixel asserts new_row. Width 1 and height 1: the first address has new_row and last both set.
- Arithmetic is incremental only (no multiplier). All address math is modulo 2^ADDR_W; wrap-around is silent.
- start while busy or in FIN: ignored; the latched configuration does not change.
- abort (highest priority after reset) in any state: go to IDLE next cycle; addr_valid=0, busy=0, no done.
- abort and start in the same cycle: abort wins; the start is dropped.
- Configuration inputs are sampled only on an accepted start.

Optional Feature:
- Macro ADDR_GEN_OVF_EN.
- Defined: adds output addr_ovf (1 bit), a sticky flag set when any address increment or decrement carries or borrows out of ADDR_W bits. It is cleared on reset and on an accepted start. Address values themselves still wrap.
- Undefined: port absent; wrap is silent.

Decomposition:
- Package addr_gen_pkg holds:
  - state enum {IDLE, RUN, FIN};
  - a config struct {start_addr, img_width, img_height, line_stride, col_dir, row_dir};
  - the PIX_BYTES default.
- One sub-module, addr_step: a registered signed-step accumulator (load, step-enable, direction, step magnitude, with optional carry-out). It is instantiated twice, once for addr and once for row_base.

Test Plan:
- Reset held 3 cycles, then released with start=0 -> all outputs 0 and busy=0 for 3 further cycles.
- start_addr=100, width=3, height=2, stride=64, both dirs 0, ready always 1 -> addr sequence 100, 104, 108, 164, 168, 172; new_row on 100 and 164; last on 172; done one cycle after 172 is accepted.
- Same configuration with col_dir=1, row_dir=1, start_addr=1000 -> 1000, 996, 992, 936, 932, 928.
- ready toggled 1,0,0,1 during the forward case -> addr holds during the ready=0 cycles; total of 6 transfers; sequence unchanged.
- width=0, start pulsed -> addr_valid never high; done pulses on the second cycle after start.
- abort on the 3rd accepted address, then a new start with start_addr=0xFFFF_FFFC, width=2, height=1 -> no done for the aborted frame; new frame emits 0xFFFF_FFFC then 0x0000_0000. With ADDR_GEN_OVF_EN defined, addr_ovf=1 after the wrap.

Source files
------------

// File: rtl/addr_gen_pkg.sv
// ---------------------------------------------------------------------------
// addr_gen_pkg
//   Shared types for the 2-D address generator.
//   - state_t : controller FSM states
//   - cfg_t   : frame configuration bundle (as presented on start)
//   - AG_*    : default widths and pixel size used by addr_gen_2d
// ---------------------------------------------------------------------------
package addr_gen_pkg;

   localparam int AG_ADDR_W    = 32;
   localparam int AG_DIM_W     = 10;
   localparam int AG_PIX_BYTES = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   typedef struct packed {
      logic [AG_ADDR_W-1:0] start_addr;
      logic [AG_DIM_W-1:0]  img_width;
      logic [AG_DIM_W-1:0]  img_height;
      logic [AG_ADDR_W-1:0] line_stride;
      logic                 col_dir;
      logic                 row_dir;
   } cfg_t;

endpackage

// File: rtl/addr_step.sv
// ---------------------------------------------------------------------------
// addr_step
//   Registered accumulator that either loads a value or steps by +/- a
//   magnitude. Load has priority over step.
//   Ports:
//     i_clk, i_n_rst   clock, synchronous active-low reset (value -> 0)
//     i_load           load i_load_val this cycle
//     i_load_val       value to load
//     i_en             step this cycle (ignored when i_load)
//     i_dir            0: add i_mag, 1: subtract i_mag
//     i_mag            step magnitude (unsigned)
//     o_val            current accumulator value
//     o_nxt            value after one step (o_val +/- i_mag, wrapped)
//     o_cy             carry/borrow out of the step (ADDR_GEN_OVF_EN only)
// ---------------------------------------------------------------------------
module addr_step #(
   parameter int W = 32
) (
   input  logic         i_clk,
   input  logic         i_n_rst,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_en,
   input  logic         i_dir,
   input  logic [W-1:0] i_mag,
`ifdef ADDR_GEN_OVF_EN
   output logic         o_cy,
`endif
   output logic [W-1:0] o_val,
   output logic [W-1:0] o_nxt
);

   logic [W-1:0] r_val;
   logic [W:0]   w_sum;

   // One extra bit catches the carry on add and the borrow on subtract.
   always_comb begin
      if (i_dir) w_sum = {1'b0, r_val} - {1'b0, i_mag};
      else       w_sum = {1'b0, r_val} + {1'b0, i_mag};
   end

   always_ff @(posedge i_clk) begin
      if (!i_n_rst)    r_val <= '0;
      else if (i_load) r_val <= i_load_val;
      else if (i_en)   r_val <= w_sum[W-1:0];
   end

   assign o_val = r_val;
   assign o_nxt = w_sum[W-1:0];
`ifdef ADDR_GEN_OVF_EN
   assign o_cy  = w_sum[W];
`endif

endmodule

// File: rtl/addr_gen_2d.sv
// ---------------------------------------------------------------------------
// addr_gen_2d
//   Emits one pixel address per valid/ready transfer across a
//   width x height window with programmable stride and independent
//   row/column direction (raster, mirror, flip, rotate-180).
//   Ports:
//     clk, n_rst                 clock, synchronous active-low reset
//     start, abort               begin frame (IDLE only) / drop frame
//     start_addr .. row_dir      frame configuration, sampled on start
//     addr_ready                 consumer handshake
//     addr, addr_valid           address stream
//     row_cnt, col_cnt           position of the current address
//     new_row, last              first pixel of row / final pixel of frame
//     busy, done                 frame in progress / completion pulse
//     addr_ovf                   sticky wrap flag (ADDR_GEN_OVF_EN only)
//   Optional feature macro: ADDR_GEN_OVF_EN
// ---------------------------------------------------------------------------
module addr_gen_2d
   import addr_gen_pkg::*;
#(
   parameter int ADDR_W    = AG_ADDR_W,
   parameter int DIM_W     = AG_DIM_W,
   parameter int PIX_BYTES = AG_PIX_BYTES
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [DIM_W-1:0]  img_width,
   input  logic [DIM_W-1:0]  img_height,
   input  logic [ADDR_W-1:0] line_stride,
   input  logic              col_dir,
   input  logic              row_dir,
   input  logic              addr_ready,
   output logic [ADDR_W-1:0] addr,
   output logic              addr_valid,
   output logic [DIM_W-1:0]  row_cnt,
   output logic [DIM_W-1:0]  col_cnt,
   output logic              new_row,
   output logic              last,
   output logic              busy,
`ifdef ADDR_GEN_OVF_EN
   output logic              addr_ovf,
`endif
   output logic              done
);

   cfg_t              w_cfg;
   state_t            r_state;
   logic [DIM_W-1:0]  r_width, r_height, r_col, r_row;
   logic [ADDR_W-1:0] r_stride;
   logic              r_col_dir, r_row_dir;
   logic              r_valid, r_busy, r_new_row, r_last, r_done;

   logic              w_xfer, w_col_end, w_col_adv, w_row_adv;
   logic              w_size_ok, w_start_acc, w_start_ok;
   logic [ADDR_W-1:0] w_addr_val, w_addr_nxt, w_row_val, w_row_nxt;
   logic              w_unused_addr_nxt;

   assign w_cfg.start_addr  = AG_ADDR_W'(start_addr);
   assign w_cfg.img_width   = AG_DIM_W'(img_width);
   assign w_cfg.img_height  = AG_DIM_W'(img_height);
   assign w_cfg.line_stride = AG_ADDR_W'(line_stride);
   assign w_cfg.col_dir     = col_dir;
   assign w_cfg.row_dir     = row_dir;

   // abort cancels any transfer presented in the same cycle
   assign w_xfer      = r_valid & addr_ready & ~abort;
   assign w_col_end   = (r_col == r_width - DIM_W'(1));
   assign w_col_adv   = w_xfer & ~w_col_end;
   assign w_row_adv   = w_xfer & w_col_end & ~r_last;
   assign w_size_ok   = (w_cfg.img_width != '0) & (w_cfg.img_height != '0);
   assign w_start_acc = (r_state == IDLE) & start & ~abort;
   assign w_start_ok  = w_start_acc & w_size_ok;

`ifdef ADDR_GEN_OVF_EN
   logic w_addr_cy, w_row_cy, r_ovf;
`endif

   // Current address: steps along a row, reloads with the next row base at
   // the end of a row.
   addr_step #(.W(ADDR_W)) u_addr (
      .i_clk      (clk),
      .i_n_rst    (n_rst),
      .i_load     (w_start_ok | w_row_adv),
      .i_load_val (w_start_ok ? ADDR_W'(w_cfg.start_addr) : w_row_nxt),
      .i_en       (w_col_adv),
      .i_dir      (r_col_dir),
      .i_mag      (ADDR_W'(PIX_BYTES)),
`ifdef ADDR_GEN_OVF_EN
      .o_cy       (w_addr_cy),
`endif
      .o_val      (w_addr_val),
      .o_nxt      (w_addr_nxt)
   );

   // Row base: address of column 0 of the current row.
   addr_step #(.W(ADDR_W)) u_row (
      .i_clk      (clk),
      .i_n_rst    (n_rst),
      .i_load     (w_start_ok),
      .i_load_val (ADDR_W'(w_cfg.start_addr)),
      .i_en       (w_row_adv),
      .i_dir      (r_row_dir),
      .i_mag      (r_stride),
`ifdef ADDR_GEN_OVF_EN
      .o_cy       (w_row_cy),
`endif
      .o_val      (w_row_val),
      .o_nxt      (w_row_nxt)
   );

   // The column accumulator's look-ahead value has no consumer.
   assign w_unused_addr_nxt = ^{w_addr_nxt, w_row_val};

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         r_state   <= IDLE;
         r_width   <= '0;
         r_height  <= '0;
         r_stride  <= '0;
         r_col_dir <= 1'b0;
         r_row_dir <= 1'b0;
         r_col     <= '0;
         r_row     <= '0;
         r_valid   <= 1'b0;
         r_busy    <= 1'b0;
         r_new_row <= 1'b0;
         r_last    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (abort) begin
            r_state   <= IDLE;
            r_col     <= '0;
            r_row     <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_new_row <= 1'b0;
            r_last    <= 1'b0;
         end else begin
            case (r_state)
               IDLE: begin
                  if (start) begin
                     r_width   <= DIM_W'(w_cfg.img_width);
                     r_height  <= DIM_W'(w_cfg.img_height);
                     r_stride  <= ADDR_W'(w_cfg.line_stride);
                     r_col_dir <= w_cfg.col_dir;
                     r_row_dir <= w_cfg.row_dir;
                     r_col     <= '0;
                     r_row     <= '0;
                     if (w_size_ok) begin
                        r_state   <= RUN;
                        r_valid   <= 1'b1;
                        r_busy    <= 1'b1;
                        r_new_row <= 1'b1;
                        r_last    <= (w_cfg.img_width  == AG_DIM_W'(1)) &&
                                     (w_cfg.img_height == AG_DIM_W'(1));
                     end else begin
                        r_state <= FIN;
                     end
                  end
               end
               RUN: begin
                  if (w_xfer) begin
                     if (r_last) begin
                        r_state   <= FIN;
                        r_valid   <= 1'b0;
                        r_busy    <= 1'b0;
                        r_new_row <= 1'b0;
                        r_last    <= 1'b0;
                     end else if (w_col_end) begin
                        r_col     <= '0;
                        r_row     <= r_row + DIM_W'(1);
                        r_new_row <= 1'b1;
                        r_last    <= (r_width == DIM_W'(1)) &&
                                     (r_row + DIM_W'(1) == r_height - DIM_W'(1));
                     end else begin
                        r_col     <= r_col + DIM_W'(1);
                        r_new_row <= 1'b0;
                        r_last    <= (r_col + DIM_W'(1) == r_width - DIM_W'(1)) &&
                                     (r_row == r_height - DIM_W'(1));
                     end
                  end
               end
               FIN: begin
                  r_done  <= 1'b1;
                  r_state <= IDLE;
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

`ifdef ADDR_GEN_OVF_EN
   // Sticky: any carry/borrow of either accumulator on an actual step.
   always_ff @(posedge clk) begin
      if (!n_rst)           r_ovf <= 1'b0;
      else if (w_start_acc) r_ovf <= 1'b0;
      else if ((w_col_adv & w_addr_cy) | (w_row_adv & w_row_cy))
                            r_ovf <= 1'b1;
   end
   assign addr_ovf = r_ovf;
`endif

   assign addr       = w_addr_val;
   assign addr_valid = r_valid;
   assign row_cnt    = r_row;
   assign col_cnt    = r_col;
   assign new_row    = r_new_row;
   assign last       = r_last;
   assign busy       = r_busy;
   assign done       = r_done;

endmodule

// File: tb/tb_addr_gen_2d.sv
// ---------------------------------------------------------------------------
// tb_addr_gen_2d
//   Scoreboard bench for addr_gen_2d: expected pixels are queued when a
//   frame is started and compared as the DUT hands them over.
// ---------------------------------------------------------------------------
module tb_addr_gen_2d;

   logic        clk = 1'b0;
   logic        n_rst, start, abort, col_dir, row_dir, addr_ready;
   logic [31:0] start_addr, line_stride, addr;
   logic [9:0]  img_width, img_height, row_cnt, col_cnt;
   logic        addr_valid, new_row, last, busy, done;
`ifdef ADDR_GEN_OVF_EN
   logic        addr_ovf;
`endif

   always #5 clk = ~clk;

   addr_gen_2d dut (
      .clk        (clk),
      .n_rst      (n_rst),
      .start      (start),
      .abort      (abort),
      .start_addr (start_addr),
      .img_width  (img_width),
      .img_height (img_height),
      .line_stride(line_stride),
      .col_dir    (col_dir),
      .row_dir    (row_dir),
      .addr_ready (addr_ready),
      .addr       (addr),
      .addr_valid (addr_valid),
      .row_cnt    (row_cnt),
      .col_cnt    (col_cnt),
      .new_row    (new_row),
      .last       (last),
      .busy       (busy),
`ifdef ADDR_GEN_OVF_EN
      .addr_ovf   (addr_ovf),
`endif
      .done       (done)
   );

   typedef struct {
      logic [31:0] a;
      logic [9:0]  r;
      logic [9:0]  c;
      logic        nr;
      logic        lst;
   } exp_t;

   exp_t     q[$];
   int       n_vec = 0, n_err = 0;
   int       acc_cnt = 0, done_cnt = 0;
   int       rdy_i = 0;
   bit       rdy_mode = 1'b0;
   bit [3:0] pat = 4'b1001;   // ready sequence 1,0,0,1 (bit 0 first)

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   // Monitor: outputs sampled on the falling edge, clear of the active edge.
   always @(negedge clk) begin
      exp_t e;
      if (n_rst && done) done_cnt++;
      if (n_rst && addr_valid && !abort) begin
         if (q.size() == 0) begin
            if (addr_ready) chk("unexpected_xfer", {32'd0, addr}, 64'hFFFF_FFFF);
         end else begin
            e = q[0];
            if (addr_ready) begin
               void'(q.pop_front());
               acc_cnt++;
               chk("addr",    {32'd0, addr}, {32'd0, e.a});
               chk("row_cnt", {54'd0, row_cnt}, {54'd0, e.r});
               chk("col_cnt", {54'd0, col_cnt}, {54'd0, e.c});
               chk("new_row", {63'd0, new_row}, {63'd0, e.nr});
               chk("last",    {63'd0, last},    {63'd0, e.lst});
            end else begin
               chk("hold_addr", {32'd0, addr}, {32'd0, e.a});
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      rdy_i++;
      addr_ready = rdy_mode ? pat[rdy_i % 4] : 1'b1;
   endtask

   task automatic push_frame(input logic [31:0] sa, input int w, input int h,
                             input logic [31:0] st, input bit cd, input bit rd);
      logic [31:0] rs, cs;
      exp_t        e;
      rs = rd ? (32'd0 - st) : st;
      cs = cd ? 32'hFFFF_FFFC : 32'd4;
      for (int r = 0; r < h; r++)
         for (int c = 0; c < w; c++) begin
            e.a   = sa + rs * 32'(r) + cs * 32'(c);
            e.r   = 10'(r);
            e.c   = 10'(c);
            e.nr  = (c == 0);
            e.lst = (r == h - 1) && (c == w - 1);
            q.push_back(e);
         end
   endtask

   task automatic drive_cfg(input logic [31:0] sa, input int w, input int h,
                            input logic [31:0] st, input bit cd, input bit rd);
      start_addr  = sa;
      img_width   = 10'(w);
      img_height  = 10'(h);
      line_stride = st;
      col_dir     = cd;
      row_dir     = rd;
   endtask

   task automatic run_frame(input logic [31:0] sa, input int w, input int h,
                            input logic [31:0] st, input bit cd, input bit rd,
                            input bit mode, input bit bstart);
      int n0, d0;
      push_frame(sa, w, h, st, cd, rd);
      n0 = acc_cnt;
      d0 = done_cnt;
      rdy_mode = mode;
      drive_cfg(sa, w, h, st, cd, rd);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("lat_valid", {63'd0, addr_valid}, 64'd1);
      chk("lat_busy",  {63'd0, busy}, 64'd1);
      chk("lat_addr",  {32'd0, addr}, {32'd0, sa});
      if (bstart) begin
         // start while busy must be ignored, whatever the config says
         tick();
         drive_cfg(32'h0000_0005, 7, 9, 32'd12, ~cd, ~rd);
         start = 1'b1;
         tick();
         start = 1'b0;
      end
      for (int i = 0; i < 300 && done_cnt == d0; i++) tick();
      if (done_cnt == d0) chk("done_timeout", 64'd0, 64'd1);
      tick();
      tick();
      chk("queue_empty", 64'(q.size()), 64'd0);
      chk("xfer_count",  64'(acc_cnt - n0), 64'(w * h));
      chk("done_once",   64'(done_cnt - d0), 64'd1);
      chk("idle_busy",   {63'd0, busy}, 64'd0);
      q.delete();
      rdy_mode = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      n_rst = 1'b0; start = 1'b0; abort = 1'b0; addr_ready = 1'b1;
      drive_cfg(32'd0, 0, 0, 32'd0, 1'b0, 1'b0);

      tick(); tick(); tick();
      n_rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("reset_outputs",
             {26'd0, addr, addr_valid, row_cnt, col_cnt, new_row, last, busy, done}, 64'd0);
         tick();
      end

      // forward raster, ready always high
      run_frame(32'd100, 3, 2, 32'd64, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef ADDR_GEN_OVF_EN
      chk("ovf_clear", {63'd0, addr_ovf}, 64'd0);
`endif
      // rotate-180
      run_frame(32'd1000, 3, 2, 32'd64, 1'b1, 1'b1, 1'b0, 1'b0);
      // forward with ready 1,0,0,1 and a start while busy
      run_frame(32'd100, 3, 2, 32'd64, 1'b0, 1'b0, 1'b1, 1'b1);
      // single pixel: new_row and last together
      run_frame(32'd40, 1, 1, 32'd16, 1'b0, 1'b0, 1'b0, 1'b0);
      // one column, vertical flip: new_row on every pixel
      run_frame(32'h200, 1, 3, 32'd16, 1'b0, 1'b1, 1'b1, 1'b0);

      // zero width: no address, done on the second cycle after start
      drive_cfg(32'd0, 0, 5, 32'd8, 1'b0, 1'b0);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("zw_valid1", {63'd0, addr_valid}, 64'd0);
      chk("zw_done1",  {63'd0, done}, 64'd0);
      tick();
      chk("zw_valid2", {63'd0, addr_valid}, 64'd0);
      chk("zw_done2",  {63'd0, done}, 64'd1);
      tick();
      chk("zw_done3",  {63'd0, done}, 64'd0);

      // abort on the third presented address
      push_frame(32'd100, 3, 2, 32'd64, 1'b0, 1'b0);
      drive_cfg(32'd100, 3, 2, 32'd64, 1'b0, 1'b0);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      chk("abort_pre", {32'd0, addr}, 64'd108);
      d0 = done_cnt;
      abort = 1'b1;
      start = 1'b1;
      tick();
      abort = 1'b0;
      start = 1'b0;
      q.delete();
      chk("abort_valid", {63'd0, addr_valid}, 64'd0);
      chk("abort_busy",  {63'd0, busy}, 64'd0);
      tick(); tick(); tick();
      chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
      chk("abort_idle_valid", {63'd0, addr_valid}, 64'd0);

      // wrap across the top of the address space
      run_frame(32'hFFFF_FFFC, 2, 1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef ADDR_GEN_OVF_EN
      chk("ovf_set", {63'd0, addr_ovf}, 64'd1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
